// File: rtl/zwa_pkg.sv
// Shared types and defaults for the zone grayscale frame-buffer write arbiter.
package zwa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    XFER,
    DONE,
    ABORT
  } state_t;

  localparam int ZONES_DEF   = 1024;
  localparam int AW_DEF      = 10;
  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 4096;

  localparam logic REQ_ALG  = 1'b0;
  localparam logic REQ_TEST = 1'b1;

endpackage

// File: rtl/zwa_rr_arb.sv
// Two-way round-robin pick with a force override favouring the test requester.
module zwa_rr_arb
  import zwa_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic force_req,
  input  logic last,
  output logic winner,
  output logic any
);

  // "last" is the requester served most recently; the other one gets priority.
  always_comb begin
    any = req0 | req1;
    if (force_req && req1) begin
      winner = REQ_TEST;
    end else if (last == REQ_ALG) begin
      winner = req1 ? REQ_TEST : REQ_ALG;
    end else begin
      winner = req0 ? REQ_ALG : REQ_TEST;
    end
  end

endmodule

// File: rtl/zone_write_arbiter.sv
// Whole-frame arbiter for the zone frame-buffer write port (sdbpflag/wtaddr/wtdina).
// Optional statistics counters are built when ZWA_STATS_EN is defined.
module zone_write_arbiter
  import zwa_pkg::*;
#(
  parameter int ZONES   = ZONES_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_req0,
  input  logic          I_req1,
  input  logic          I_force_test,
  output logic          O_gnt0,
  output logic          O_gnt1,
  input  logic          I_vld0,
  input  logic          I_vld1,
  input  logic [AW-1:0] I_addr0,
  input  logic [AW-1:0] I_addr1,
  input  logic [DW-1:0] I_data0,
  input  logic [DW-1:0] I_data1,
  output logic          O_sdbpflag,
  output logic          O_wten,
  output logic [AW-1:0] O_wtaddr,
  output logic [DW-1:0] O_wtdina,
  output logic          O_frame_done,
  output logic          O_abort,
  output logic          O_addr_err,
  output logic [15:0]   O_stat_frm0,
  output logic [15:0]   O_stat_frm1,
  output logic [15:0]   O_stat_abt
);

  localparam int CW = $clog2(ZONES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WC_LAST = CW'(ZONES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [31:0]   ZONES_U = 32'(ZONES);

  state_t        state, next_state;
  logic          owner, last, winner, any;
  logic [CW-1:0] wcount;
  logic [TW-1:0] tcount, tinc;
  logic          sel_req, sel_vld;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          in_xfer, addr_ok, accept, last_write, timeout_hit;
  logic          sdbp_d, gnt0_d, gnt1_d, wten_d, done_d, abort_d, err_d;
  logic [AW-1:0] waddr_d;
  logic [DW-1:0] wdata_d;

  zwa_rr_arb u_arb (
    .req0      (I_req0),
    .req1      (I_req1),
    .force_req (I_force_test),
    .last      (last),
    .winner    (winner),
    .any       (any)
  );

  // Only the current owner's request and write lanes matter.
  always_comb begin
    sel_req  = (owner == REQ_TEST) ? I_req1  : I_req0;
    sel_vld  = (owner == REQ_TEST) ? I_vld1  : I_vld0;
    sel_addr = (owner == REQ_TEST) ? I_addr1 : I_addr0;
    sel_data = (owner == REQ_TEST) ? I_data1 : I_data0;
  end

  assign in_xfer    = (state == XFER);
  assign addr_ok    = (32'(sel_addr) < ZONES_U);
  assign accept     = in_xfer & sel_vld & addr_ok;
  assign last_write = accept & (wcount == WC_LAST);
  assign tinc       = (tcount == TO_MAX) ? tcount : tcount + TW'(1);
  // A write landing on the expiry cycle is still written, but the frame is abandoned.
  assign timeout_hit = in_xfer & (tinc == TO_MAX);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any) next_state = START;
      START:   next_state = XFER;
      XFER: begin
        if (last_write) begin
          next_state = DONE;
        end else if (timeout_hit || !sel_req) begin
          next_state = ABORT;
        end
      end
      DONE:    next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that they align with the state they describe.
  always_comb begin
    sdbp_d  = (next_state == START);
    gnt0_d  = (next_state == XFER) && (owner == REQ_ALG);
    gnt1_d  = (next_state == XFER) && (owner == REQ_TEST);
    wten_d  = accept;
    waddr_d = accept ? sel_addr : O_wtaddr;
    wdata_d = accept ? sel_data : O_wtdina;
    done_d  = (next_state == DONE);
    abort_d = (next_state == ABORT);
    err_d   = in_xfer & sel_vld & ~addr_ok;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_sdbpflag   <= 1'b0;
      O_gnt0       <= 1'b0;
      O_gnt1       <= 1'b0;
      O_wten       <= 1'b0;
      O_wtaddr     <= '0;
      O_wtdina     <= '0;
      O_frame_done <= 1'b0;
      O_abort      <= 1'b0;
      O_addr_err   <= 1'b0;
    end else begin
      O_sdbpflag   <= sdbp_d;
      O_gnt0       <= gnt0_d;
      O_gnt1       <= gnt1_d;
      O_wten       <= wten_d;
      O_wtaddr     <= waddr_d;
      O_wtdina     <= wdata_d;
      O_frame_done <= done_d;
      O_abort      <= abort_d;
      O_addr_err   <= err_d;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      owner  <= REQ_ALG;
      last   <= REQ_ALG;
      wcount <= '0;
      tcount <= '0;
    end else begin
      if (state == IDLE && any) begin
        owner <= winner;
      end
      if (state == DONE || state == ABORT) begin
        last <= owner;
      end
      if (state == START) begin
        wcount <= '0;
        tcount <= '0;
      end else if (in_xfer) begin
        if (accept) begin
          wcount <= wcount + CW'(1);
          tcount <= '0;
        end else begin
          tcount <= tinc;
        end
      end
    end
  end

`ifdef ZWA_STATS_EN
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_stat_frm0 <= '0;
      O_stat_frm1 <= '0;
      O_stat_abt  <= '0;
    end else begin
      if (next_state == DONE && owner == REQ_ALG) O_stat_frm0 <= O_stat_frm0 + 16'd1;
      if (next_state == DONE && owner == REQ_TEST) O_stat_frm1 <= O_stat_frm1 + 16'd1;
      if (next_state == ABORT) O_stat_abt <= O_stat_abt + 16'd1;
    end
  end
`else
  assign O_stat_frm0 = '0;
  assign O_stat_frm1 = '0;
  assign O_stat_abt  = '0;
`endif

endmodule

// File: tb/tb_zone_write_arbiter.sv
// Scoreboard bench for zone_write_arbiter: frames, arbitration, timeout, address errors, reset.
`timescale 1ns/1ps
module tb_zone_write_arbiter;
  import zwa_pkg::*;

  localparam int ZONES   = 1000;
  localparam int AW      = AW_DEF;
  localparam int DW      = DW_DEF;
  localparam int TIMEOUT = TIMEOUT_DEF;

  logic          I_clk = 1'b0;
  logic          I_rst_n = 1'b0;
  logic          I_req0 = 1'b0, I_req1 = 1'b0, I_force_test = 1'b0;
  logic          I_vld0 = 1'b0, I_vld1 = 1'b0;
  logic [AW-1:0] I_addr0 = '0, I_addr1 = '0;
  logic [DW-1:0] I_data0 = '0, I_data1 = '0;
  logic          O_gnt0, O_gnt1, O_sdbpflag, O_wten, O_frame_done, O_abort, O_addr_err;
  logic [AW-1:0] O_wtaddr;
  logic [DW-1:0] O_wtdina;
  logic [15:0]   O_stat_frm0, O_stat_frm1, O_stat_abt;

  zone_write_arbiter #(.ZONES(ZONES), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_req0(I_req0), .I_req1(I_req1), .I_force_test(I_force_test),
    .O_gnt0(O_gnt0), .O_gnt1(O_gnt1),
    .I_vld0(I_vld0), .I_vld1(I_vld1),
    .I_addr0(I_addr0), .I_addr1(I_addr1),
    .I_data0(I_data0), .I_data1(I_data1),
    .O_sdbpflag(O_sdbpflag), .O_wten(O_wten), .O_wtaddr(O_wtaddr), .O_wtdina(O_wtdina),
    .O_frame_done(O_frame_done), .O_abort(O_abort), .O_addr_err(O_addr_err),
    .O_stat_frm0(O_stat_frm0), .O_stat_frm1(O_stat_frm1), .O_stat_abt(O_stat_abt)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            at;
  } wr_t;

  wr_t sb[$];
  int  checks = 0, errors = 0, cyc = 0;
  int  sdbp_cnt = 0, sdbp_cyc = 0, gnt_rise_cyc = 0;
  int  done_cnt = 0, done_cyc = 0, abort_cnt = 0, abort_cyc = 0;
  int  err_cnt = 0, last_wten_cyc = 0;
  logic gnt_prev = 1'b0;
  int  model_last = 0, exp_frm0 = 0, exp_frm1 = 0, exp_abt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  always @(posedge I_clk) cyc++;

  // Output monitor: pulse bookkeeping and scoreboard pops.
  always @(negedge I_clk) begin
    wr_t w;
    if (O_sdbpflag) begin sdbp_cnt++; sdbp_cyc = cyc; end
    if ((O_gnt0 | O_gnt1) && !gnt_prev) gnt_rise_cyc = cyc;
    gnt_prev = O_gnt0 | O_gnt1;
    if (O_frame_done) begin done_cnt++; done_cyc = cyc; end
    if (O_abort) begin abort_cnt++; abort_cyc = cyc; end
    if (O_addr_err) err_cnt++;
    if (O_wten) begin
      last_wten_cyc = cyc;
      checkOutput("wten_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        checkOutput("wtaddr", 32'(O_wtaddr), 32'(w.addr));
        checkOutput("wtdina", 32'(O_wtdina), 32'(w.data));
        checkOutput("wten_latency", cyc - w.at, 1);
      end
    end
  end

  function automatic int expectedWinner();
    if (I_force_test && I_req1) return 1;
    if (model_last == 0) return I_req1 ? 1 : 0;
    return I_req0 ? 0 : 1;
  endfunction

  function automatic int statExp(input int v);
`ifdef ZWA_STATS_EN
    return v & 16'hFFFF;
`else
    return 0 * v;
`endif
  endfunction

  task automatic setVld(input int r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (r == 0) begin I_vld0 = v; I_addr0 = a; I_data0 = d; end
    else begin I_vld1 = v; I_addr1 = a; I_data1 = d; end
  endtask

  task automatic waitAnyGnt(output int owner, output bit ok);
    ok = 1'b0;
    owner = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge I_clk); #1;
      if (O_gnt0 | O_gnt1) ok = 1'b1;
    end
    checkOutput("gnt_wait", 32'(ok), 1);
    if (ok) begin
      checkOutput("gnt_onehot", 32'(O_gnt0 & O_gnt1), 0);
      owner = O_gnt1 ? 1 : 0;
    end
  endtask

  // Drives n consecutive owner writes starting at address first; each is expected on O_wten.
  task automatic applyStimulus(input int r, input int n, input int first);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      a = AW'(first + i);
      d = DW'(first + i) ^ ((r == 1) ? 16'h8000 : 16'h0000);
      setVld(r, 1'b1, a, d);
      sb.push_back('{addr: a, data: d, at: cyc});
      @(negedge I_clk); #1;
    end
    setVld(r, 1'b0, '0, '0);
  endtask

  task automatic runFrame();
    int exp_owner, owner, d0;
    bit ok;
    exp_owner = expectedWinner();
    waitAnyGnt(owner, ok);
    if (!ok) return;
    checkOutput("owner", owner, exp_owner);
    checkOutput("sdbp_lead", gnt_rise_cyc - sdbp_cyc, 1);
    d0 = done_cnt;
    applyStimulus(owner, ZONES, 0);
    checkOutput("frame_done", done_cnt - d0, 1);
    checkOutput("done_align", done_cyc, last_wten_cyc);
    checkOutput("gnt_drop", {30'd0, O_gnt1, O_gnt0}, 0);
    checkOutput("sb_empty", sb.size(), 0);
    model_last = owner;
    if (owner == 1) exp_frm1++; else exp_frm0++;
  endtask

  initial begin
    #300_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int owner, a0, e0, d0, s0;
    bit ok;

    #3;
    checkOutput("reset_ctl", {25'd0, O_sdbpflag, O_gnt0, O_gnt1, O_wten, O_frame_done, O_abort, O_addr_err}, 0);
    checkOutput("reset_bus", {6'd0, O_wtaddr, O_wtdina}, 0);
    repeat (3) @(negedge I_clk);
    #1 I_rst_n = 1'b1;
    repeat (3) @(negedge I_clk);
    #1;
    checkOutput("idle_no_sdbp", sdbp_cnt, 0);

    $display("[TB] single requester full frame");
    I_req0 = 1'b1;
    runFrame();

    $display("[TB] both requesters, round-robin then forced");
    I_req1 = 1'b1;
    runFrame();
    runFrame();
    I_force_test = 1'b1;
    runFrame();
    runFrame();
    I_force_test = 1'b0;
    I_req1 = 1'b0;

    $display("[TB] stall timeout");
    waitAnyGnt(owner, ok);
    checkOutput("to_owner", owner, 0);
    a0 = abort_cnt;
    applyStimulus(0, 10, 0);
    for (int i = 0; i < TIMEOUT + 20 && abort_cnt == a0; i++) begin
      @(negedge I_clk); #1;
    end
    checkOutput("abort_seen", abort_cnt - a0, 1);
    checkOutput("abort_timing", abort_cyc - last_wten_cyc, TIMEOUT);
    model_last = 0;
    exp_abt++;
    runFrame();

    $display("[TB] non-owner strobes and out-of-range address");
    waitAnyGnt(owner, ok);
    checkOutput("err_owner", owner, 0);
    d0 = done_cnt;
    applyStimulus(0, 300, 0);
    e0 = err_cnt;
    setVld(1, 1'b1, AW'(5), 16'h1234);
    @(negedge I_clk); #1;
    setVld(1, 1'b0, '0, '0);
    setVld(0, 1'b1, AW'(1010), 16'h0BAD);
    @(negedge I_clk); #1;
    setVld(0, 1'b0, '0, '0);
    @(negedge I_clk); #1;
    checkOutput("addr_err", err_cnt - e0, 1);
    checkOutput("no_early_done", done_cnt - d0, 0);
    applyStimulus(0, 700, 300);
    checkOutput("err_frame_done", done_cnt - d0, 1);
    checkOutput("err_sb_empty", sb.size(), 0);
    model_last = 0;
    exp_frm0++;

    $display("[TB] request withdrawn on an accepted write");
    waitAnyGnt(owner, ok);
    a0 = abort_cnt;
    applyStimulus(0, 499, 0);
    setVld(0, 1'b1, AW'(499), 16'h01F3);
    sb.push_back('{addr: AW'(499), data: 16'h01F3, at: cyc});
    I_req0 = 1'b0;
    @(negedge I_clk); #1;
    setVld(0, 1'b0, '0, '0);
    checkOutput("wd_abort", abort_cnt - a0, 1);
    checkOutput("wd_abort_align", abort_cyc, last_wten_cyc);
    checkOutput("wd_sb_empty", sb.size(), 0);
    model_last = 0;
    exp_abt++;

    $display("[TB] asynchronous reset mid-frame");
    I_req0 = 1'b1;
    waitAnyGnt(owner, ok);
    applyStimulus(0, 20, 0);
    checkOutput("stat_frm0", 32'(O_stat_frm0), statExp(exp_frm0));
    checkOutput("stat_frm1", 32'(O_stat_frm1), statExp(exp_frm1));
    checkOutput("stat_abt", 32'(O_stat_abt), statExp(exp_abt));
    a0 = abort_cnt;
    d0 = done_cnt;
    #2 I_rst_n = 1'b0;
    #1;
    checkOutput("rst_ctl", {25'd0, O_sdbpflag, O_gnt0, O_gnt1, O_wten, O_frame_done, O_abort, O_addr_err}, 0);
    checkOutput("rst_bus", {6'd0, O_wtaddr, O_wtdina}, 0);
    checkOutput("rst_stats", {O_stat_frm0, O_stat_frm1 | O_stat_abt}, 0);
    I_req0 = 1'b0;
    repeat (2) @(negedge I_clk);
    #1 I_rst_n = 1'b1;
    model_last = 0;
    s0 = sdbp_cnt;
    repeat (5) @(negedge I_clk);
    #1;
    checkOutput("post_rst_idle", {29'd0, O_gnt0, O_gnt1, O_sdbpflag}, 0);
    checkOutput("post_rst_sdbp", sdbp_cnt - s0, 0);
    checkOutput("post_rst_pulses", (abort_cnt - a0) + (done_cnt - d0), 0);

    I_req0 = 1'b1;
    I_req1 = 1'b1;
    a0 = expectedWinner();
    waitAnyGnt(owner, ok);
    checkOutput("post_rst_rr", owner, a0);
    I_req0 = 1'b0;
    I_req1 = 1'b0;
    repeat (4) @(negedge I_clk);
    #1;
    checkOutput("final_idle", {30'd0, O_gnt0, O_gnt1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
